strip_header: RTL

- Receive end of the length-header packet protocol.
- The input stream carries packets, each preceded by a 1-data-cycle header whose bits [15:0] give the byte length of the following packet.
- The block removes the header and forwards the payload beats on axis_out. tlast and the last-beat tkeep are regenerated from the header length.
- The length goes out on a parallel axis_plen stream. Length/tlast disagreements are flagged and counted.

---
 rtl/strip_header.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/strip_header.sv
// strip_header: receive side of the length-header packet protocol.
// The first beat of every packet is a header whose low 16 bits give the
// payload length in bytes. The header is consumed here, its length goes out
// on axis_plen, and the payload is forwarded with tkeep/tlast rebuilt from
// that length. Upstream tlast is only compared against the length.
//
// state | meaning
// HDR   | waiting for a header beat; input ready follows the plen slot
// DATA  | forwarding payload beats; input ready follows the output slot

module strip_header #(
    parameter int DW = 128
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DW-1:0]     axis_in_tdata,
    input  logic [DW/8-1:0]   axis_in_tkeep,
    input  logic              axis_in_tlast,
    input  logic              axis_in_tvalid,
    output logic              axis_in_tready,
    output logic [DW-1:0]     axis_out_tdata,
    output logic [DW/8-1:0]   axis_out_tkeep,
    output logic              axis_out_tlast,
    output logic              axis_out_tvalid,
    input  logic              axis_out_tready,
    output logic [15:0]       axis_plen_tdata,
    output logic              axis_plen_tvalid,
    input  logic              axis_plen_tready,
    output logic              err_mismatch,
    output logic [15:0]       err_count
);

    localparam int          BPB     = DW / 8;
    localparam logic [15:0] BPB_LEN = 16'(BPB);

    typedef enum logic {
        HDR  = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [15:0]     remaining;
    logic            live;
    logic            out_free;
    logic            plen_free;
    logic            hdr_fire;
    logic            data_fire;
    logic            final_beat;
    logic [15:0]     hdr_len;
    logic [BPB-1:0]  last_keep;
    logic            hdr_err;
    logic            data_err;
    logic            err_cond;

    // Incoming tkeep carries no information here; the length header decides.
    logic unused_tkeep;
    assign unused_tkeep = ^axis_in_tkeep;

    assign out_free   = !axis_out_tvalid || axis_out_tready;
    assign plen_free  = !axis_plen_tvalid || axis_plen_tready;
    assign hdr_len    = axis_in_tdata[15:0];
    assign final_beat = (remaining <= BPB_LEN);

    // Keep mask for the closing beat: one bit per byte still owed.
    always_comb begin
        last_keep = '0;
        for (int i = 0; i < BPB; i++) begin
            last_keep[i] = (16'(i) < remaining);
        end
    end

    // Held low through reset so the input port reads not-ready while resetn=0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: a non-empty header opens a packet, the final beat closes it.
    always_comb begin
        state_nxt = state;
        case (state)
            HDR: begin
                if (hdr_fire && (hdr_len != 16'd0)) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (data_fire && final_beat) begin
                    state_nxt = HDR;
                end
            end
            default: state_nxt = HDR;
        endcase
    end

    // Input handshake: a header needs a free plen slot, payload a free output slot.
    always_comb begin
        axis_in_tready = 1'b0;
        hdr_fire       = 1'b0;
        data_fire      = 1'b0;
        case (state)
            HDR:     axis_in_tready = live && plen_free;
            DATA:    axis_in_tready = live && out_free;
            default: axis_in_tready = 1'b0;
        endcase
        if (axis_in_tvalid && axis_in_tready) begin
            hdr_fire  = (state == HDR);
            data_fire = (state == DATA);
        end
    end

    // Length/tlast disagreement: empty or tlast-marked header, or a tlast that
    // does not line up with the beat the length says is last.
    always_comb begin
        hdr_err  = hdr_fire && ((hdr_len == 16'd0) || axis_in_tlast);
        data_err = data_fire && (axis_in_tlast != final_beat);
        err_cond = hdr_err || data_err;
    end

    // Byte countdown for the packet in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            remaining <= 16'd0;
        end else if (hdr_fire && (hdr_len != 16'd0)) begin
            remaining <= hdr_len;
        end else if (data_fire) begin
            if (final_beat) begin
                remaining <= 16'd0;
            end else begin
                remaining <= remaining - BPB_LEN;
            end
        end
    end

    // Payload output register; holds its contents while stalled.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            axis_out_tdata  <= '0;
            axis_out_tkeep  <= '0;
            axis_out_tlast  <= 1'b0;
            axis_out_tvalid <= 1'b0;
        end else if (data_fire) begin
            axis_out_tdata  <= axis_in_tdata;
            axis_out_tkeep  <= final_beat ? last_keep : {BPB{1'b1}};
            axis_out_tlast  <= final_beat;
            axis_out_tvalid <= 1'b1;
        end else if (axis_out_tready) begin
            axis_out_tvalid <= 1'b0;
        end
    end

    // Length output register; a single slot, so a new header waits for it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            axis_plen_tdata  <= 16'd0;
            axis_plen_tvalid <= 1'b0;
        end else if (hdr_fire && (hdr_len != 16'd0)) begin
            axis_plen_tdata  <= hdr_len;
            axis_plen_tvalid <= 1'b1;
        end else if (axis_plen_tready) begin
            axis_plen_tvalid <= 1'b0;
        end
    end

    // Error pulse and its saturating tally move together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_mismatch <= 1'b0;
            err_count    <= 16'd0;
        end else begin
            err_mismatch <= err_cond;
            if (err_cond && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule
